rle_bitstream_writer: RTL and testbench

- Parametrised run-length decompressor/writer for the DCNN IO path.
- Consumes a stream of (bit value, run length) tokens and expands each run into a packed, MSB-first bit stream in byte/word-addressed RAM.
- Starts at an arbitrary word/bit position and merges partial head and tail words by read-modify-write, so RAM bits outside the written span are preserved.
- Sits between the compressed-token source and the RAM arbiter, and reports the next free position on completion.

---
 rtl/rle_bitstream_writer_if.sv | 36 +++
 rtl/rle_bitstream_writer.sv | 209 ++++++++++++++++++++
 tb/tb_rle_bitstream_writer.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/rle_bitstream_writer_if.sv
// Token, control and RAM-port bundle for the run-length bitstream writer.
// The slave modport is the writer's view; master is the token source / RAM side.
interface rle_bitstream_writer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 7,
  parameter int BIT_W  = $clog2(DATA_W)
);
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic [BIT_W-1:0]  start_bit;
  logic              tok_valid;
  logic              tok_ready;
  logic              tok_bit;
  logic [LEN_W-1:0]  tok_len;
  logic              tok_last;
  logic              busy;
  logic              done;
  logic [ADDR_W-1:0] end_addr;
  logic [BIT_W-1:0]  end_bit;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_rd;
  logic              ram_wr;

  modport slave (
    input  start, start_addr, start_bit, tok_valid, tok_bit, tok_len, tok_last, ram_rdata,
    output tok_ready, busy, done, end_addr, end_bit, ram_addr, ram_wdata, ram_rd, ram_wr
  );

  modport master (
    output start, start_addr, start_bit, tok_valid, tok_bit, tok_len, tok_last, ram_rdata,
    input  tok_ready, busy, done, end_addr, end_bit, ram_addr, ram_wdata, ram_rd, ram_wr
  );
endinterface

// File: rtl/rle_bitstream_writer.sv
// Expands (bit, run length) tokens into a packed MSB-first bitstream in RAM,
// merging partial head/tail words by read-modify-write.
module rle_bitstream_writer #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16,
  parameter int LEN_W  = 7,
  parameter int BIT_W  = $clog2(DATA_W)
) (
  input logic                  clk,
  input logic                  rst_n,
  rle_bitstream_writer_if.slave bus
);

  localparam int CNT_W = (LEN_W > BIT_W + 1) ? LEN_W : BIT_W + 1;
  localparam logic [BIT_W-1:0] PTR_TOP = BIT_W'(DATA_W - 1);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_RD_HEAD   = 4'd1,
    S_WAIT_HEAD = 4'd2,
    S_TOKEN     = 4'd3,
    S_RUN       = 4'd4,
    S_WR_WORD   = 4'd5,
    S_RD_TAIL   = 4'd6,
    S_WAIT_TAIL = 4'd7,
    S_WR_TAIL   = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t            r_state,    w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [BIT_W-1:0]  r_ptr,      w_ptr_nxt;
  logic [DATA_W-1:0] r_acc,      w_acc_nxt;
  logic [LEN_W-1:0]  r_run_rem,  w_run_rem_nxt;
  logic              r_val,      w_val_nxt;
  logic              r_last,     w_last_nxt;

  logic [CNT_W-1:0]  w_room;
  logic [CNT_W-1:0]  w_rem_ext;
  logic [CNT_W-1:0]  w_n;
  logic [DATA_W-1:0] w_tail_data;

  logic              r_tok_ready, r_busy, r_done, r_ram_rd, r_ram_wr;
  logic [ADDR_W-1:0] r_end_addr, r_ram_addr;
  logic [BIT_W-1:0]  r_end_bit;
  logic [DATA_W-1:0] r_ram_wdata;

  logic              w_rd_nxt, w_wr_nxt;

  // Next-state and datapath update for the token/run/merge sequencer.
  always_comb begin
    w_state_nxt    = r_state;
    w_cur_addr_nxt = r_cur_addr;
    w_ptr_nxt      = r_ptr;
    w_acc_nxt      = r_acc;
    w_run_rem_nxt  = r_run_rem;
    w_val_nxt      = r_val;
    w_last_nxt     = r_last;
    w_rem_ext      = CNT_W'(r_run_rem);
    w_room         = CNT_W'(r_ptr) + CNT_W'(1);
    w_n            = (w_rem_ext < w_room) ? w_rem_ext : w_room;
    w_tail_data    = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i > int'(r_ptr)) begin
        w_tail_data[i] = r_acc[i];
      end else begin
        w_tail_data[i] = bus.ram_rdata[i];
      end
    end

    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_cur_addr_nxt = bus.start_addr;
          w_ptr_nxt      = bus.start_bit;
          if (bus.start_bit != PTR_TOP) begin
            w_state_nxt = S_RD_HEAD;
          end else begin
            w_acc_nxt   = '0;
            w_state_nxt = S_TOKEN;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_HEAD:   w_state_nxt = S_WAIT_HEAD;
      S_WAIT_HEAD: begin
        w_acc_nxt   = bus.ram_rdata;
        w_state_nxt = S_TOKEN;
      end
      S_TOKEN: begin
        if (bus.tok_valid) begin
          w_run_rem_nxt = bus.tok_len;
          w_val_nxt     = bus.tok_bit;
          w_last_nxt    = bus.tok_last;
          w_state_nxt   = S_RUN;
        end else begin
          w_state_nxt = S_TOKEN;
        end
      end
      S_RUN: begin
        for (int i = 0; i < DATA_W; i++) begin
          if ((i <= int'(r_ptr)) && ((i + int'(w_n)) > int'(r_ptr))) begin
            w_acc_nxt[i] = r_val;
          end else begin
            w_acc_nxt[i] = r_acc[i];
          end
        end
        w_run_rem_nxt = r_run_rem - LEN_W'(w_n);
        // When the word does not fill, the whole remaining run fit, so run_rem is now zero.
        if (w_n == w_room) begin
          w_state_nxt = S_WR_WORD;
        end else begin
          w_ptr_nxt = r_ptr - BIT_W'(w_n);
          if (!r_last) begin
            w_state_nxt = S_TOKEN;
          end else if (w_ptr_nxt == PTR_TOP) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_RD_TAIL;
          end
        end
      end
      S_WR_WORD: begin
        w_cur_addr_nxt = r_cur_addr + ADDR_W'(1);
        w_ptr_nxt      = PTR_TOP;
        w_acc_nxt      = '0;
        if (r_run_rem != '0) begin
          w_state_nxt = S_RUN;
        end else if (!r_last) begin
          w_state_nxt = S_TOKEN;
        end else begin
          w_state_nxt = S_DONE;
        end
      end
      S_RD_TAIL:   w_state_nxt = S_WAIT_TAIL;
      S_WAIT_TAIL: w_state_nxt = S_WR_TAIL;
      S_WR_TAIL:   w_state_nxt = S_DONE;
      S_DONE:      w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  assign w_rd_nxt = (w_state_nxt == S_RD_HEAD) || (w_state_nxt == S_RD_TAIL);
  assign w_wr_nxt = (w_state_nxt == S_WR_WORD) || (w_state_nxt == S_WR_TAIL);

  // Sequencer state and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cur_addr <= '0;
      r_ptr      <= '0;
      r_acc      <= '0;
      r_run_rem  <= '0;
      r_val      <= 1'b0;
      r_last     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cur_addr <= w_cur_addr_nxt;
      r_ptr      <= w_ptr_nxt;
      r_acc      <= w_acc_nxt;
      r_run_rem  <= w_run_rem_nxt;
      r_val      <= w_val_nxt;
      r_last     <= w_last_nxt;
    end
  end

  // Outputs are decoded from the next state so each strobe lines up with its state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tok_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_ram_rd    <= 1'b0;
      r_ram_wr    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_end_addr  <= '0;
      r_end_bit   <= '0;
    end else begin
      r_tok_ready <= (w_state_nxt == S_TOKEN);
      r_busy      <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_DONE);
      r_done      <= (w_state_nxt == S_DONE);
      r_ram_rd    <= w_rd_nxt;
      r_ram_wr    <= w_wr_nxt;
      r_ram_addr  <= (w_rd_nxt || w_wr_nxt) ? w_cur_addr_nxt : '0;
      r_ram_wdata <= (w_state_nxt == S_WR_WORD) ? w_acc_nxt :
                     (w_state_nxt == S_WR_TAIL) ? w_tail_data : '0;
      if (w_state_nxt == S_DONE) begin
        r_end_addr <= w_cur_addr_nxt;
        r_end_bit  <= w_ptr_nxt;
      end else begin
        r_end_addr <= r_end_addr;
        r_end_bit  <= r_end_bit;
      end
    end
  end

  assign bus.tok_ready = r_tok_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.end_addr  = r_end_addr;
  assign bus.end_bit   = r_end_bit;
  assign bus.ram_addr  = r_ram_addr;
  assign bus.ram_wdata = r_ram_wdata;
  assign bus.ram_rd    = r_ram_rd;
  assign bus.ram_wr    = r_ram_wr;

endmodule

// File: tb/tb_rle_bitstream_writer.sv
// Directed bench for rle_bitstream_writer: token scenarios against a small RAM model.
module tb_rle_bitstream_writer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [7:0] mem [0:255] = '{default: 8'h00};
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  int   both_cnt = 0;
  logic       poke_en = 1'b0;
  logic [7:0] poke_addr = 8'h00;
  logic [7:0] poke_data = 8'h00;

  rle_bitstream_writer_if #(.DATA_W(8), .ADDR_W(16), .LEN_W(7)) bus ();

  rle_bitstream_writer #(.DATA_W(8), .ADDR_W(16), .LEN_W(7)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: single-cycle write, read data one cycle after the strobe.
  always @(posedge clk) begin
    if (poke_en) begin
      mem[poke_addr] <= poke_data;
    end else if (bus.ram_wr) begin
      mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end
    if (bus.ram_rd) begin
      bus.ram_rdata <= mem[bus.ram_addr[7:0]];
    end
    if (bus.ram_rd) rd_cnt <= rd_cnt + 1;
    if (bus.ram_wr) wr_cnt <= wr_cnt + 1;
    if (bus.ram_rd && bus.ram_wr) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    poke_addr = a;
    poke_data = d;
    poke_en   = 1'b1;
    @(negedge clk);
    poke_en   = 1'b0;
  endtask

  task automatic do_start(input logic [15:0] a, input logic [2:0] b);
    bus.start_addr = a;
    bus.start_bit  = b;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start      = 1'b0;
  endtask

  task automatic send_tok(input string tag, input logic b, input logic [6:0] len, input logic last);
    int k;
    bus.tok_bit   = b;
    bus.tok_len   = len;
    bus.tok_last  = last;
    bus.tok_valid = 1'b1;
    k = 0;
    while (!bus.tok_ready && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " tok_ready"}, {31'd0, bus.tok_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.tok_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(input string tag, input logic [15:0] ea, input logic [2:0] eb);
    int k;
    k = 0;
    while (!bus.done && k < 1000) begin
      @(negedge clk);
      k++;
    end
    chk({tag, " done"}, {31'd0, bus.done}, 32'd1);
    chk({tag, " busy_low"}, {31'd0, bus.busy}, 32'd0);
    chk({tag, " end_addr"}, {16'd0, bus.end_addr}, {16'd0, ea});
    chk({tag, " end_bit"}, {29'd0, bus.end_bit}, {29'd0, eb});
    @(negedge clk);
  endtask

  initial begin
    int r0, w0;
    bus.start = 1'b0;
    bus.start_addr = 16'h0000;
    bus.start_bit = 3'd0;
    bus.tok_valid = 1'b0;
    bus.tok_bit = 1'b0;
    bus.tok_len = 7'd0;
    bus.tok_last = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst busy", {31'd0, bus.busy}, 32'd0);
    chk("rst tok_ready", {31'd0, bus.tok_ready}, 32'd0);
    chk("rst ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("rst end_addr", {16'd0, bus.end_addr}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Scenario 1: aligned full word
    poke(8'h11, 8'h3C);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0010, 3'd7);
    chk("s1 busy", {31'd0, bus.busy}, 32'd1);
    send_tok("s1", 1'b1, 7'd8, 1'b1);
    wait_done("s1", 16'h0011, 3'd7);
    chk("s1 reads", rd_cnt - r0, 32'd0);
    chk("s1 writes", wr_cnt - w0, 32'd1);
    chk("s1 mem10", {24'd0, mem[8'h10]}, 32'h0000_00FF);
    chk("s1 mem11", {24'd0, mem[8'h11]}, 32'h0000_003C);

    // Scenario 2: head and tail in one word
    poke(8'h20, 8'hA5);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0020, 3'd3);
    send_tok("s2", 1'b0, 7'd2, 1'b1);
    wait_done("s2", 16'h0020, 3'd1);
    chk("s2 reads", rd_cnt - r0, 32'd2);
    chk("s2 writes", wr_cnt - w0, 32'd1);
    chk("s2 mem20", {24'd0, mem[8'h20]}, 32'h0000_00A1);

    // Scenario 3: two tokens spanning two words
    poke(8'h30, 8'h55);
    poke(8'h31, 8'hAA);
    poke(8'h32, 8'h77);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0030, 3'd7);
    send_tok("s3a", 1'b1, 7'd12, 1'b0);
    send_tok("s3b", 1'b0, 7'd4, 1'b1);
    wait_done("s3", 16'h0032, 3'd7);
    chk("s3 reads", rd_cnt - r0, 32'd0);
    chk("s3 writes", wr_cnt - w0, 32'd2);
    chk("s3 mem30", {24'd0, mem[8'h30]}, 32'h0000_00FF);
    chk("s3 mem31", {24'd0, mem[8'h31]}, 32'h0000_00F0);
    chk("s3 mem32", {24'd0, mem[8'h32]}, 32'h0000_0077);

    // Scenario 4: zero-length run
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0040, 3'd7);
    send_tok("s4", 1'b1, 7'd0, 1'b1);
    wait_done("s4", 16'h0040, 3'd7);
    chk("s4 reads", rd_cnt - r0, 32'd0);
    chk("s4 writes", wr_cnt - w0, 32'd0);

    // Scenario 5: gap between tokens, start pulsed while busy
    poke(8'h99, 8'h42);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0050, 3'd7);
    send_tok("s5a", 1'b1, 7'd12, 1'b0);
    for (int k = 0; k < 50 && !bus.tok_ready; k++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("s5 gap tok_ready", {31'd0, bus.tok_ready}, 32'd1);
      if (k == 1) begin
        bus.start_addr = 16'h0099;
        bus.start_bit  = 3'd2;
        bus.start      = 1'b1;
      end else begin
        bus.start      = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
    chk("s5 gap reads", rd_cnt - r0, 32'd0);
    chk("s5 gap writes", wr_cnt - w0, 32'd1);
    send_tok("s5b", 1'b0, 7'd4, 1'b1);
    wait_done("s5", 16'h0052, 3'd7);
    chk("s5 writes", wr_cnt - w0, 32'd2);
    chk("s5 mem50", {24'd0, mem[8'h50]}, 32'h0000_00FF);
    chk("s5 mem51", {24'd0, mem[8'h51]}, 32'h0000_00F0);
    chk("s5 mem99", {24'd0, mem[8'h99]}, 32'h0000_0042);

    // Scenario 6: reset in the middle of a long run
    poke(8'h6C, 8'h5A);
    do_start(16'h0060, 3'd7);
    send_tok("s6", 1'b1, 7'd100, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    chk("s6 busy_before", {31'd0, bus.busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("s6 async busy", {31'd0, bus.busy}, 32'd0);
    chk("s6 async ram_wr", {31'd0, bus.ram_wr}, 32'd0);
    chk("s6 async ram_addr", {16'd0, bus.ram_addr}, 32'd0);
    w0 = wr_cnt;
    repeat (5) @(negedge clk);
    chk("s6 no writes", wr_cnt - w0, 32'd0);
    chk("s6 mem6C", {24'd0, mem[8'h6C]}, 32'h0000_005A);
    rst_n = 1'b1;
    @(negedge clk);
    r0 = rd_cnt; w0 = wr_cnt;
    do_start(16'h0070, 3'd7);
    send_tok("s6r", 1'b1, 7'd8, 1'b1);
    wait_done("s6r", 16'h0071, 3'd7);
    chk("s6r writes", wr_cnt - w0, 32'd1);
    chk("s6r mem70", {24'd0, mem[8'h70]}, 32'h0000_00FF);

    chk("rd_wr exclusive", both_cnt, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
